// File: rtl/reg_status_file.sv
// Architectural register file with a per-register rename-tag table.
// Combinational source-operand reads with commit bypass; commit, rename and flush update on posedge.
module reg_status_file #(
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      REG_W    = 5,
    parameter int unsigned      TAG_W    = 4,
    parameter logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  rs1_name,
    input  logic [REG_W-1:0]  rs2_name,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0] rs1_data,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              rename_en,
    input  logic [REG_W-1:0]  rename_reg,
    input  logic [TAG_W-1:0]  rename_tag,
    input  logic              commit_en,
    input  logic [REG_W-1:0]  commit_reg,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              flush
);

    localparam int unsigned NUM_REGS = 2 ** REG_W;

    logic [DATA_W-1:0] data_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_q  [NUM_REGS];

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = commit_en && (commit_reg != '0);
    assign rename_ok = rename_en && (rename_reg != '0) && !flush;

    // Later assignments win: rename overrides commit's tag clear, flush overrides both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= TAG_FREE;
            end
        end else begin
            if (commit_ok) begin
                data_q[commit_reg] <= commit_data;
                if (tag_q[commit_reg] == commit_tag) begin
                    tag_q[commit_reg] <= TAG_FREE;
                end
            end
            if (rename_ok) begin
                tag_q[rename_reg] <= rename_tag;
            end
            if (flush) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    tag_q[i] <= TAG_FREE;
                end
            end
        end
    end

    // A same-cycle commit resolves the operand when it is the pending producer, or when
    // nothing is pending (the register is about to hold commit_data). A same-cycle
    // rename is deliberately invisible here.
    function automatic logic [TAG_W+DATA_W-1:0] read_port(
        input logic [REG_W-1:0]  name,
        input logic [TAG_W-1:0]  cur_tag,
        input logic [DATA_W-1:0] cur_data
    );
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              hit;
        tag  = TAG_FREE;
        data = '0;
        hit  = commit_en && (commit_reg == name);
        if (name != '0) begin
            if (hit && ((commit_tag == cur_tag) || (cur_tag == TAG_FREE))) begin
                tag  = TAG_FREE;
                data = commit_data;
            end else begin
                tag  = cur_tag;
                data = (cur_tag == TAG_FREE) ? cur_data : '0;
            end
        end
        return {tag, data};
    endfunction

    assign {rs1_tag, rs1_data} = read_port(rs1_name, tag_q[rs1_name], data_q[rs1_name]);
    assign {rs2_tag, rs2_data} = read_port(rs2_name, tag_q[rs2_name], data_q[rs2_name]);

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios plus randomized traffic
// against an array-based model of register values and pending producer tags.
module tb_reg_status_file;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned NREGS  = 32;
    localparam logic [TAG_W-1:0] FREE = 4'b1000;

    logic              clk;
    logic              rst;
    logic [REG_W-1:0]  rs1_name, rs2_name;
    logic [TAG_W-1:0]  rs1_tag, rs2_tag;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              rename_en;
    logic [REG_W-1:0]  rename_reg;
    logic [TAG_W-1:0]  rename_tag;
    logic              commit_en;
    logic [REG_W-1:0]  commit_reg;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;
    logic              flush;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] m_data [NREGS];
    logic [TAG_W-1:0]  m_tag  [NREGS];

    reg_status_file #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TAG_W   (TAG_W),
        .TAG_FREE(FREE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_name   (rs1_name),
        .rs2_name   (rs2_name),
        .rs1_tag    (rs1_tag),
        .rs1_data   (rs1_data),
        .rs2_tag    (rs2_tag),
        .rs2_data   (rs2_data),
        .rename_en  (rename_en),
        .rename_reg (rename_reg),
        .rename_tag (rename_tag),
        .commit_en  (commit_en),
        .commit_reg (commit_reg),
        .commit_data(commit_data),
        .commit_tag (commit_tag),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_data[i] = '0;
            m_tag[i]  = FREE;
        end
    endfunction

    // Expected read: x0 is constant; a commit to a register whose pending producer is the
    // committing entry (or that has no pending producer) delivers the committed value.
    function automatic logic [TAG_W+DATA_W-1:0] expect_read(input logic [REG_W-1:0] n);
        if (n == 0) return {FREE, 32'h0};
        if (commit_en && commit_reg == n && (commit_tag == m_tag[n] || m_tag[n] == FREE))
            return {FREE, commit_data};
        if (m_tag[n] == FREE) return {FREE, m_data[n]};
        return {m_tag[n], 32'h0};
    endfunction

    task automatic idle();
        rename_en   = 1'b0;
        rename_reg  = '0;
        rename_tag  = '0;
        commit_en   = 1'b0;
        commit_reg  = '0;
        commit_data = '0;
        commit_tag  = '0;
        flush       = 1'b0;
    endtask

    // One clock: the model absorbs this cycle's commit/rename/flush, then inputs return to idle.
    task automatic step();
        logic [TAG_W-1:0] nt [NREGS];
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) nt[i] = m_tag[i];
            if (commit_en && commit_reg != 0) begin
                m_data[commit_reg] = commit_data;
                if (m_tag[commit_reg] == commit_tag) nt[commit_reg] = FREE;
            end
            if (rename_en && rename_reg != 0 && !flush) nt[rename_reg] = rename_tag;
            if (flush) for (int i = 0; i < NREGS; i++) nt[i] = FREE;
            for (int i = 0; i < NREGS; i++) m_tag[i] = nt[i];
        end
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        rs1_name = 5'd5;
        rs2_name = 5'd7;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'h0})
            $display("FAIL reset_x5: got tag=%h data=%h, want tag=%h data=0", rs1_tag, rs1_data, FREE);
        else n_pass++;
        n_checks++;
        if ({rs2_tag, rs2_data} !== {FREE, 32'h0})
            $display("FAIL reset_x7: got tag=%h data=%h, want tag=%h data=0", rs2_tag, rs2_data, FREE);
        else n_pass++;
    endtask

    task automatic test_commit_free();
        commit_en = 1'b1; commit_reg = 5'd5; commit_data = 32'hDEAD; commit_tag = 4'h2;
        rs1_name = 5'd5;
        step();
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'hDEAD})
            $display("FAIL commit_free_x5: got tag=%h data=%h, want tag=8 data=0000dead", rs1_tag, rs1_data);
        else n_pass++;
    endtask

    task automatic test_rename_commit();
        rename_en = 1'b1; rename_reg = 5'd3; rename_tag = 4'h1;
        step();
        rs1_name = 5'd3;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data} !== {4'h1, 32'h0})
            $display("FAIL renamed_x3: got tag=%h data=%h, want tag=1 data=0", rs1_tag, rs1_data);
        else n_pass++;
        commit_en = 1'b1; commit_reg = 5'd3; commit_data = 32'd7; commit_tag = 4'h1;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'd7})
            $display("FAIL bypass_x3: got tag=%h data=%h, want tag=8 data=7", rs1_tag, rs1_data);
        else n_pass++;
        step();
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'd7})
            $display("FAIL stored_x3: got tag=%h data=%h, want tag=8 data=7", rs1_tag, rs1_data);
        else n_pass++;
    endtask

    task automatic test_stale_commit();
        rename_en = 1'b1; rename_reg = 5'd4; rename_tag = 4'h2;
        step();
        rename_en = 1'b1; rename_reg = 5'd4; rename_tag = 4'h5;
        step();
        rs2_name = 5'd4;
        commit_en = 1'b1; commit_reg = 5'd4; commit_data = 32'd9; commit_tag = 4'h2;
        #1;
        n_checks++;
        if ({rs2_tag, rs2_data} !== {4'h5, 32'h0})
            $display("FAIL stale_bypass_x4: got tag=%h data=%h, want tag=5 data=0", rs2_tag, rs2_data);
        else n_pass++;
        step();
        n_checks++;
        if ({rs2_tag, rs2_data} !== {4'h5, 32'h0})
            $display("FAIL stale_stored_x4: got tag=%h data=%h, want tag=5 data=0", rs2_tag, rs2_data);
        else n_pass++;
        commit_en = 1'b1; commit_reg = 5'd4; commit_data = 32'd11; commit_tag = 4'h5;
        step();
        n_checks++;
        if ({rs2_tag, rs2_data} !== {FREE, 32'd11})
            $display("FAIL young_commit_x4: got tag=%h data=%h, want tag=8 data=b", rs2_tag, rs2_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        rename_en = 1'b1; rename_reg = 5'd6; rename_tag = 4'h3;
        rs1_name = 5'd6;
        #1;
        n_checks++;
        if (rs1_tag !== FREE)
            $display("FAIL rename_hidden_x6: got tag=%h, want tag=8", rs1_tag);
        else n_pass++;
        step();
        n_checks++;
        if (rs1_tag !== 4'h3)
            $display("FAIL rename_visible_x6: got tag=%h, want tag=3", rs1_tag);
        else n_pass++;
    endtask

    task automatic test_rename_and_commit_flush();
        rename_en = 1'b1; rename_reg = 5'd8; rename_tag = 4'h1;
        step();
        commit_en = 1'b1; commit_reg = 5'd8; commit_data = 32'h1234_5678; commit_tag = 4'h1;
        rename_en = 1'b1; rename_reg = 5'd8; rename_tag = 4'h6;
        step();
        rs1_name = 5'd8;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data} !== {4'h6, 32'h0})
            $display("FAIL rename_wins_x8: got tag=%h data=%h, want tag=6 data=0", rs1_tag, rs1_data);
        else n_pass++;
        rename_en = 1'b1; rename_reg = 5'd9; rename_tag = 4'h2;
        flush = 1'b1;
        step();
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'h1234_5678})
            $display("FAIL flush_x8: got tag=%h data=%h, want tag=8 data=12345678", rs1_tag, rs1_data);
        else n_pass++;
        rs2_name = 5'd9;
        #1;
        n_checks++;
        if (rs2_tag !== FREE)
            $display("FAIL flush_drops_rename_x9: got tag=%h, want tag=8", rs2_tag);
        else n_pass++;
        for (int r = 1; r < NREGS; r++) begin
            rs1_name = REG_W'(r);
            #1;
            n_checks++;
            if (rs1_tag !== FREE)
                $display("FAIL flush_all_tags: reg %0d got tag=%h, want tag=8", r, rs1_tag);
            else n_pass++;
        end
    endtask

    task automatic test_x0();
        rename_en = 1'b1; rename_reg = 5'd0; rename_tag = 4'h4;
        commit_en = 1'b1; commit_reg = 5'd0; commit_data = 32'hFFFF_FFFF; commit_tag = FREE;
        rs1_name = 5'd0;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'h0})
            $display("FAIL x0_bypass: got tag=%h data=%h, want tag=8 data=0", rs1_tag, rs1_data);
        else n_pass++;
        step();
        n_checks++;
        if ({rs1_tag, rs1_data} !== {FREE, 32'h0})
            $display("FAIL x0_stored: got tag=%h data=%h, want tag=8 data=0", rs1_tag, rs1_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [TAG_W+DATA_W-1:0] e1, e2;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rename_en  = ($urandom_range(0, 2) != 0);
            rename_reg = REG_W'($urandom_range(0, 11));
            rename_tag = TAG_W'($urandom_range(0, 7));
            commit_en  = ($urandom_range(0, 1) != 0);
            commit_reg = REG_W'($urandom_range(0, 11));
            commit_data = $urandom;
            if (m_tag[commit_reg] != FREE && $urandom_range(0, 3) != 0)
                commit_tag = m_tag[commit_reg];
            else
                commit_tag = TAG_W'($urandom_range(0, 7));
            flush = ($urandom_range(0, 39) == 0);
            rs1_name = ($urandom_range(0, 2) == 0) ? commit_reg : REG_W'($urandom_range(0, 11));
            rs2_name = ($urandom_range(0, 2) == 0) ? rename_reg : REG_W'($urandom_range(0, 11));
            #1;
            e1 = expect_read(rs1_name);
            e2 = expect_read(rs2_name);
            n_checks++;
            if ({rs1_tag, rs1_data} !== e1)
                $display("FAIL random_rs1: cycle %0d reg %0d got %h_%h, want %h_%h",
                         cyc, rs1_name, rs1_tag, rs1_data, e1[35:32], e1[31:0]);
            else n_pass++;
            n_checks++;
            if ({rs2_tag, rs2_data} !== e2)
                $display("FAIL random_rs2: cycle %0d reg %0d got %h_%h, want %h_%h",
                         cyc, rs2_name, rs2_tag, rs2_data, e2[35:32], e2[31:0]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        commit_en = 1'b1; commit_reg = 5'd10; commit_data = 32'hAA; commit_tag = 4'h0;
        step();
        rename_en = 1'b1; rename_reg = 5'd11; rename_tag = 4'h4;
        step();
        rs1_name = 5'd10;
        rs2_name = 5'd11;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data, rs2_tag} !== {FREE, 32'hAA, 4'h4})
            $display("FAIL pre_reset: got %h_%h_%h, want 8_000000aa_4", rs1_tag, rs1_data, rs2_tag);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rs1_tag, rs1_data, rs2_tag, rs2_data} !== {FREE, 32'h0, FREE, 32'h0})
            $display("FAIL async_reset: got %h_%h_%h_%h, want 8_00000000_8_00000000",
                     rs1_tag, rs1_data, rs2_tag, rs2_data);
        else n_pass++;
        model_reset();
        rename_en = 1'b1; rename_reg = 5'd12; rename_tag = 4'h3;
        commit_en = 1'b1; commit_reg = 5'd13; commit_data = 32'h55; commit_tag = FREE;
        step();
        rst = 1'b0;
        rs1_name = 5'd12;
        rs2_name = 5'd13;
        #1;
        n_checks++;
        if ({rs1_tag, rs2_tag, rs2_data} !== {FREE, FREE, 32'h0})
            $display("FAIL reset_drops_updates: got %h_%h_%h, want 8_8_00000000", rs1_tag, rs2_tag, rs2_data);
        else n_pass++;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rs1_name = '0;
        rs2_name = '0;
        test_reset();
        test_commit_free();
        test_rename_commit();
        test_stale_commit();
        test_back_to_back();
        test_rename_and_commit_flush();
        test_x0();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
